// File: rtl/axi4_video_pattern_gen.sv
// Synthetic AXI4-Stream video source: X_RES x Y_RES frames with tuser = SOF, tlast = EOL.
// Four test patterns, selection latched only at the start of each frame.
module axi4_video_pattern_gen #(
  parameter int unsigned X_RES      = 1920,
  parameter int unsigned Y_RES      = 1080,
  parameter int unsigned PX_WIDTH   = 10,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [1:0]            pattern_i,
  output logic [3*PX_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o,
  output logic                  tuser_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  busy_o
);

  localparam int unsigned XW   = $clog2(X_RES);
  localparam int unsigned YW   = $clog2(Y_RES);
  localparam int unsigned BarW = X_RES / 8;
  localparam int unsigned BcW  = (BarW > 1) ? $clog2(BarW) : 1;

  localparam logic [XW-1:0]       XLast  = XW'(X_RES - 1);
  localparam logic [YW-1:0]       YLast  = YW'(Y_RES - 1);
  localparam logic [BcW-1:0]      BcLast = BcW'(BarW - 1);
  localparam logic [PX_WIDTH-1:0] Full   = {PX_WIDTH{1'b1}};
  localparam logic [PX_WIDTH-1:0] Grey   = {1'b1, {(PX_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_e                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [2:0]              bar_q, bar_d;
  logic [BcW-1:0]          bcnt_q, bcnt_d;
  logic [1:0]              pat_q, pat_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [3*PX_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    tuser_q, tuser_d;
  logic [PX_WIDTH-1:0]     pix_r, pix_g, pix_b;

  logic xfer;
  logic last_beat;

  assign xfer      = tvalid_q & tready_i;
  assign last_beat = (x_q == XLast) && (y_q == YLast);

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en_i) state_d = StActive;
      end
      StActive: begin
        if (xfer && last_beat && !en_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    bar_d       = bar_q;
    bcnt_d      = bcnt_q;
    pat_d       = pat_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          x_d    = '0;
          y_d    = '0;
          bar_d  = '0;
          bcnt_d = '0;
          pat_d  = pattern_i;
        end
      end
      StActive: begin
        if (xfer) begin
          if (x_q == XLast) begin
            x_d    = '0;
            bar_d  = '0;
            bcnt_d = '0;
            if (y_q == YLast) begin
              y_d         = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              if (en_i) pat_d = pattern_i;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
            // In-bar counter; bar index saturates so remainder pixels stay black.
            if (bcnt_q == BcLast) begin
              bcnt_d = '0;
              if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    tvalid_d = (state_d == StActive);
    tdata_d  = tvalid_d ? {pix_r, pix_g, pix_b} : '0;
    tlast_d  = tvalid_d && (x_d == XLast);
    tuser_d  = tvalid_d && (x_d == '0) && (y_d == '0);
  end

  // Pixel for the coordinate that will be presented next
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    unique case (pat_d)
      2'd0: begin
        // Bar order white..black is the 3-bit RGB mask 111,110,011,010,101,100,001,000.
        pix_r = {PX_WIDTH{~bar_d[1]}};
        pix_g = {PX_WIDTH{~bar_d[2]}};
        pix_b = {PX_WIDTH{~bar_d[0]}};
      end
      2'd1: begin
        pix_r = PX_WIDTH'(x_d);
        pix_g = PX_WIDTH'(x_d);
        pix_b = PX_WIDTH'(x_d);
      end
      2'd2: begin
        if (1'(x_d >> CHECK_LOG2) ^ 1'(y_d >> CHECK_LOG2)) begin
          pix_r = Full;
          pix_g = Full;
          pix_b = Full;
        end
      end
      2'd3: begin
        pix_r = Grey;
        pix_g = Grey;
        pix_b = Grey;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      bar_q       <= '0;
      bcnt_q      <= '0;
      pat_q       <= '0;
      frame_cnt_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      bar_q       <= bar_d;
      bcnt_q      <= bcnt_d;
      pat_q       <= pat_d;
      frame_cnt_q <= frame_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
    end
  end

  assign tdata_o     = tdata_q;
  assign tvalid_o    = tvalid_q;
  assign tlast_o     = tlast_q;
  assign tuser_o     = tuser_q;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = (state_q == StActive);

endmodule

// File: tb/tb_axi4_video_pattern_gen.sv
// Bench for axi4_video_pattern_gen: random backpressure against a coordinate-level pixel model.
module tb_axi4_video_pattern_gen;

  localparam int XR  = 16;
  localparam int YR  = 4;
  localparam int XR2 = 20;
  localparam int YR2 = 2;
  localparam int PX  = 10;
  localparam int CL  = 1;
  localparam logic [PX-1:0] F     = 10'h3FF;
  localparam logic [29:0]   WHITE = 30'h3FFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en, tready, tvalid, tlast, tuser, busy;
  logic [1:0]    pattern;
  logic [29:0]   tdata;
  logic [15:0]   fcnt;

  logic          en2, tready2, tvalid2, tlast2, tuser2, busy2;
  logic [1:0]    pattern2;
  logic [29:0]   tdata2;
  logic [15:0]   fcnt2;

  axi4_video_pattern_gen #(.X_RES(XR), .Y_RES(YR), .PX_WIDTH(PX), .CHECK_LOG2(CL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pattern_i(pattern), .tdata_o(tdata),
    .tvalid_o(tvalid), .tready_i(tready), .tlast_o(tlast), .tuser_o(tuser),
    .frame_cnt_o(fcnt), .busy_o(busy)
  );

  axi4_video_pattern_gen #(.X_RES(XR2), .Y_RES(YR2), .PX_WIDTH(PX), .CHECK_LOG2(CL)) dut20 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en2), .pattern_i(pattern2), .tdata_o(tdata2),
    .tvalid_o(tvalid2), .tready_i(tready2), .tlast_o(tlast2), .tuser_o(tuser2),
    .frame_cnt_o(fcnt2), .busy_o(busy2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: coordinate of the next expected beat
  int ex, ey, epat, exp_fcnt;
  bit m_active;
  logic [29:0] cap[$];

  function automatic logic [29:0] ref_pix(input int pat, input int x, input int y, input int xres);
    int bar;
    logic [PX-1:0] r, g, b;
    r = '0; g = '0; b = '0;
    case (pat)
      0: begin
        bar = x / (xres / 8);
        if (bar > 7) bar = 7;
        case (bar)
          0: begin r = F; g = F; b = F; end
          1: begin r = F; g = F;        end
          2: begin        g = F; b = F; end
          3: begin        g = F;        end
          4: begin r = F;        b = F; end
          5: begin r = F;               end
          6: begin               b = F; end
          default: ;
        endcase
      end
      1: begin
        r = PX'(x % 1024); g = r; b = r;
      end
      2: begin
        if ((((x >> CL) ^ (y >> CL)) & 1) == 1) begin r = F; g = F; b = F; end
      end
      default: begin
        r = 10'd512; g = 10'd512; b = 10'd512;
      end
    endcase
    return {r, g, b};
  endfunction

  task automatic do_reset();
    en = 0; tready = 0; pattern = 0;
    en2 = 0; tready2 = 0; pattern2 = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    exp_fcnt = 0; m_active = 0;
    cap.delete();
  endtask

  task automatic start_gen(input logic [1:0] pat);
    @(negedge clk);
    en = 1; pattern = pat;
    ex = 0; ey = 0; epat = int'(pat); m_active = 1;
  endtask

  // Runs until nbeats transfers have been observed, checking each against the model.
  task automatic beat_loop(input int nbeats, input int pct, input int drop_at, input int chg_at,
                           input logic [1:0] chg_pat);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [29:0] pd, expd;
    logic pl, pu;
    while (got < nbeats && cyc < nbeats * 20 + 50) begin
      @(negedge clk);
      cyc++;
      if (got == drop_at) en = 0;
      if (got == chg_at) pattern = chg_pat;
      tready = ($urandom_range(99) < pct);
      if (stalled) begin
        n_cmp++;
        if (tdata !== pd || tlast !== pl || tuser !== pu) begin
          n_err++;
          $display("FAIL hold: got %h/%b/%b want %h/%b/%b", tdata, tlast, tuser, pd, pl, pu);
        end
      end
      if (m_active && got > 0) begin
        n_cmp++;
        if (tvalid !== 1'b1) begin
          n_err++;
          $display("FAIL tvalid_drop: got %b want 1 at x=%0d y=%0d", tvalid, ex, ey);
        end
      end
      stalled = (tvalid === 1'b1) && !tready;
      pd = tdata; pl = tlast; pu = tuser;
      if (tvalid === 1'b1 && tready) begin
        expd = ref_pix(epat, ex, ey, XR);
        n_cmp++;
        if (tdata !== expd) begin
          n_err++;
          $display("FAIL pixel x=%0d y=%0d pat=%0d: got %h want %h", ex, ey, epat, tdata, expd);
        end
        n_cmp++;
        if (tlast !== (ex == XR - 1)) begin
          n_err++;
          $display("FAIL tlast x=%0d y=%0d: got %b want %b", ex, ey, tlast, (ex == XR - 1));
        end
        n_cmp++;
        if (tuser !== (ex == 0 && ey == 0)) begin
          n_err++;
          $display("FAIL tuser x=%0d y=%0d: got %b want %b", ex, ey, tuser, (ex == 0 && ey == 0));
        end
        cap.push_back(tdata);
        got++;
        if (ex == XR - 1) begin
          ex = 0;
          if (ey == YR - 1) begin
            ey = 0;
            exp_fcnt++;
            if (en) epat = int'(pattern);
            else m_active = 0;
          end else begin
            ey++;
          end
        end else begin
          ex++;
        end
      end
    end
    if (got < nbeats) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: got %0d beats want %0d", got, nbeats);
    end
    if (!m_active) begin
      @(negedge clk);
      n_cmp++;
      if (tvalid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_frame: got valid=%b busy=%b want 0/0", tvalid, busy);
      end
      n_cmp++;
      if (fcnt !== 16'(exp_fcnt)) begin
        n_err++;
        $display("FAIL frame_cnt: got %0d want %0d", fcnt, exp_fcnt);
      end
    end
  endtask

  task automatic test_reset();
    en = 1; tready = 1; pattern = 0;
    en2 = 1; tready2 = 1; pattern2 = 0;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({tvalid, tlast, tuser, busy, tdata, fcnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b l=%b u=%b busy=%b d=%h cnt=%h want all 0",
               tvalid, tlast, tuser, busy, tdata, fcnt);
    end
    n_cmp++;
    if ({tvalid2, tdata2, fcnt2, busy2} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs_x20: got v=%b d=%h cnt=%h busy=%b want 0", tvalid2, tdata2,
               fcnt2, busy2);
    end
    en = 0; en2 = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_en: got valid=%b busy=%b want 0/0", tvalid, busy);
    end
  endtask

  task automatic test_bars_frame();
    do_reset();
    start_gen(2'd0);
    beat_loop(64, 100, 1, -1, 2'd0);
    n_cmp++;
    if (cap[0] !== WHITE || cap[1] !== WHITE) begin
      n_err++;
      $display("FAIL bars_white: got %h %h want %h", cap[0], cap[1], WHITE);
    end
    n_cmp++;
    if (cap[14] !== 30'h0 || cap[15] !== 30'h0) begin
      n_err++;
      $display("FAIL bars_black: got %h %h want 0", cap[14], cap[15]);
    end
  endtask

  task automatic test_gradient_stall();
    do_reset();
    start_gen(2'd1);
    beat_loop(64, 50, 5, -1, 2'd0);
  endtask

  task automatic test_pattern_switch();
    do_reset();
    start_gen(2'd0);
    beat_loop(128, 100, 100, 20, 2'd2);
    n_cmp++;
    if (cap[64] !== 30'h0 || cap[65] !== 30'h0 || cap[66] !== WHITE || cap[67] !== WHITE) begin
      n_err++;
      $display("FAIL checker_line0: got %h %h %h %h want B,B,W,W", cap[64], cap[65], cap[66],
               cap[67]);
    end
    n_cmp++;
    if (cap[96] !== WHITE || cap[97] !== WHITE) begin
      n_err++;
      $display("FAIL checker_line2: got %h %h want W,W", cap[96], cap[97]);
    end
    n_cmp++;
    if (cap[20] !== ref_pix(0, 4, 1, XR)) begin
      n_err++;
      $display("FAIL switch_midframe: got %h want %h", cap[20], ref_pix(0, 4, 1, XR));
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    start_gen(2'd2);
    beat_loop(64, 100, 10, -1, 2'd0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_gen(2'd3);
    beat_loop(192, 70, 150, 40, 2'd1);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    start_gen(2'd1);
    beat_loop(30, 100, -1, -1, 2'd0);
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if (tvalid !== 1'b0 || tuser !== 1'b0 || tdata !== 30'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b u=%b d=%h busy=%b want 0", tvalid, tuser, tdata, busy);
    end
    @(negedge clk);
    rst_n = 1;
    ex = 0; ey = 0; epat = int'(pattern); m_active = 1; exp_fcnt = 0;
    cap.delete();
    beat_loop(64, 100, 5, -1, 2'd0);
  endtask

  task automatic test_bars_x20();
    int got = 0;
    int cyc = 0;
    int x = 0;
    int y = 0;
    logic [29:0] c2[$];
    do_reset();
    @(negedge clk);
    en2 = 1; pattern2 = 0; tready2 = 1;
    while (got < XR2 * YR2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (tvalid2 === 1'b1) begin
        n_cmp++;
        if (tdata2 !== ref_pix(0, x, y, XR2) || tlast2 !== (x == XR2 - 1) ||
            tuser2 !== (x == 0 && y == 0)) begin
          n_err++;
          $display("FAIL x20_beat x=%0d y=%0d: got %h/%b/%b want %h/%b/%b", x, y, tdata2,
                   tlast2, tuser2, ref_pix(0, x, y, XR2), (x == XR2 - 1), (x == 0 && y == 0));
        end
        c2.push_back(tdata2);
        got++;
        en2 = 0;
        if (x == XR2 - 1) begin x = 0; y++; end
        else x++;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (got != XR2 * YR2 || tvalid2 !== 1'b0 || fcnt2 !== 16'd1) begin
      n_err++;
      $display("FAIL x20_frame: got beats=%0d valid=%b cnt=%0d want %0d/0/1", got, tvalid2,
               fcnt2, XR2 * YR2);
    end
    n_cmp++;
    if (c2[12] !== 30'h3FF || c2[14] !== 30'h0 || c2[19] !== 30'h0) begin
      n_err++;
      $display("FAIL x20_edge: got %h %h %h want 3ff 0 0", c2[12], c2[14], c2[19]);
    end
  endtask

  initial begin
    test_reset();
    test_bars_frame();
    test_gradient_stall();
    test_pattern_switch();
    test_en_drop();
    test_back_to_back();
    test_reset_midframe();
    test_bars_x20();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
